// File: rtl/egg_timer_pkg.sv
// Shared state codes, BCD digit type and preset limits for the egg timer.
// The auto-clear build option is selected with the EGG_TIMER_AUTO_CLEAR_EN macro.
package egg_timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StRun   = 4'd1;
    localparam logic [3:0] StPause = 4'd2;
    localparam logic [3:0] StAlarm = 4'd3;

    localparam int unsigned MAX_MINS = 99;
    localparam int unsigned MAX_SECS = 59;

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of a four-digit BCD mm:ss value.
// An all-zero input is held at zero; dec_zero flags an all-zero result.
module bcd_mmss_dec
    import egg_timer_pkg::*;
(
    input  bcd_t ones_secs,
    input  bcd_t tens_secs,
    input  bcd_t ones_mins,
    input  bcd_t tens_mins,
    output bcd_t dec_ones_secs,
    output bcd_t dec_tens_secs,
    output bcd_t dec_ones_mins,
    output bcd_t dec_tens_mins,
    output logic dec_zero
);

    logic in_zero;

    assign in_zero = (ones_secs == 4'd0) && (tens_secs == 4'd0) &&
                     (ones_mins == 4'd0) && (tens_mins == 4'd0);

    always_comb begin
        dec_ones_secs = ones_secs;
        dec_tens_secs = tens_secs;
        dec_ones_mins = ones_mins;
        dec_tens_mins = tens_mins;
        if (!in_zero) begin
            if (ones_secs != 4'd0) begin
                dec_ones_secs = ones_secs - 4'd1;
            end else begin
                dec_ones_secs = 4'd9;
                if (tens_secs != 4'd0) begin
                    dec_tens_secs = tens_secs - 4'd1;
                end else begin
                    // Seconds wrap 00 -> 59 and borrow a minute.
                    dec_tens_secs = 4'd5;
                    if (ones_mins != 4'd0) begin
                        dec_ones_mins = ones_mins - 4'd1;
                    end else begin
                        dec_ones_mins = 4'd9;
                        dec_tens_mins = tens_mins - 4'd1;
                    end
                end
            end
        end
    end

    assign dec_zero = (dec_ones_secs == 4'd0) && (dec_tens_secs == 4'd0) &&
                      (dec_ones_mins == 4'd0) && (dec_tens_mins == 4'd0);

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer controller: preset load, 1 s BCD countdown with pause/resume and alarm.
// Define EGG_TIMER_AUTO_CLEAR_EN to make ALARM return to IDLE after ALARM_SECS ticks.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic [6:0] preset_mins,
    input  logic [5:0] preset_secs,
    output logic [3:0] ones_secs,
    output logic [3:0] tens_secs,
    output logic [3:0] ones_mins,
    output logic [3:0] tens_mins,
    output logic [3:0] state,
    output logic       running,
    output logic       alarm
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] t;
        t = v / 7'd10;
        return {t[3:0], 4'(v - t * 7'd10)};
    endfunction

    logic [3:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    bcd_t          os_q, ts_q, om_q, tm_q;
    bcd_t          os_d, ts_d, om_d, tm_d;
    logic          running_q, alarm_q;

    logic [6:0] mins_cl;
    logic [5:0] secs_cl;
    logic [7:0] mins_bcd, secs_bcd;
    logic       preset_zero;
    logic       tick;

    bcd_t dec_os, dec_ts, dec_om, dec_tm;
    logic dec_zero;

    assign mins_cl     = (preset_mins > 7'(MAX_MINS)) ? 7'(MAX_MINS) : preset_mins;
    assign secs_cl     = (preset_secs > 6'(MAX_SECS)) ? 6'(MAX_SECS) : preset_secs;
    assign mins_bcd    = to_bcd(mins_cl);
    assign secs_bcd    = to_bcd({1'b0, secs_cl});
    assign preset_zero = (mins_cl == 7'd0) && (secs_cl == 6'd0);
    assign tick        = (presc_q == PW'(CLK_HZ - 1));

    bcd_mmss_dec u_dec (
        .ones_secs     (os_q),
        .tens_secs     (ts_q),
        .ones_mins     (om_q),
        .tens_mins     (tm_q),
        .dec_ones_secs (dec_os),
        .dec_tens_secs (dec_ts),
        .dec_ones_mins (dec_om),
        .dec_tens_mins (dec_tm),
        .dec_zero      (dec_zero)
    );

`ifdef EGG_TIMER_AUTO_CLEAR_EN
    localparam int unsigned AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
    logic [AW-1:0] acnt_q, acnt_d;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        os_d    = os_q;
        ts_d    = ts_q;
        om_d    = om_q;
        tm_d    = tm_q;
`ifdef EGG_TIMER_AUTO_CLEAR_EN
        acnt_d  = (state_q == StAlarm) ? acnt_q : '0;
`endif
        unique case (state_q)
            StRun: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    {tm_d, om_d, ts_d, os_d} = {dec_tm, dec_om, dec_ts, dec_os};
                end
                if (clear) begin
                    state_d = StIdle;
                end else if (tick && dec_zero) begin
                    state_d = StAlarm;
                end else if (start_stop) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (clear) begin
                    state_d = StIdle;
                end else if (start_stop) begin
                    state_d = StRun;
                end
            end
            StAlarm: begin
`ifdef EGG_TIMER_AUTO_CLEAR_EN
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    acnt_d = acnt_q + AW'(1);
                end
                if (clear || start_stop || (tick && acnt_q == AW'(ALARM_SECS - 1))) begin
                    state_d = StIdle;
                end
`else
                if (clear || start_stop) begin
                    state_d = StIdle;
                end
`endif
            end
            default: begin
                if (start_stop && !preset_zero) begin
                    state_d = StRun;
                end
            end
        endcase

        // IDLE tracks the preset; leaving IDLE latches it as the starting count.
        if (state_d == StIdle || state_q == StIdle) begin
            presc_d = '0;
            {tm_d, om_d} = mins_bcd;
            {ts_d, os_d} = secs_bcd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            os_q      <= '0;
            ts_q      <= '0;
            om_q      <= '0;
            tm_q      <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            os_q      <= os_d;
            ts_q      <= ts_d;
            om_q      <= om_d;
            tm_q      <= tm_d;
            running_q <= (state_d == StRun);
            alarm_q   <= (state_d == StAlarm);
        end
    end

`ifdef EGG_TIMER_AUTO_CLEAR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            acnt_q <= '0;
        end else begin
            acnt_q <= acnt_d;
        end
    end
`endif

    assign ones_secs = os_q;
    assign tens_secs = ts_q;
    assign ones_mins = om_q;
    assign tens_mins = tm_q;
    assign state     = state_q;
    assign running   = running_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl with CLK_HZ=4 and ALARM_SECS=2.
// Build with EGG_TIMER_AUTO_CLEAR_EN defined to exercise the auto-clear alarm path.
module tb_egg_timer_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] preset_mins = 7'd0;
    logic [5:0] preset_secs = 6'd0;
    logic [3:0] ones_secs, tens_secs, ones_mins, tens_mins;
    logic [3:0] state;
    logic       running, alarm;
    logic [15:0] digits;

    int n_vec = 0;
    int n_err = 0;

    assign digits = {tens_mins, ones_mins, tens_secs, ones_secs};

    always #5 clock = ~clock;

    egg_timer_ctrl #(
        .CLK_HZ     (4),
        .ALARM_SECS (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start_stop  (start_stop),
        .clear       (clear),
        .preset_mins (preset_mins),
        .preset_secs (preset_secs),
        .ones_secs   (ones_secs),
        .tens_secs   (tens_secs),
        .ones_mins   (ones_mins),
        .tens_mins   (tens_mins),
        .state       (state),
        .running     (running),
        .alarm       (alarm)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        preset_mins = 7'd5;
        preset_secs = 6'd7;
        step(2);
        n_vec++;
        if ({state, running, alarm} !== 6'b0000_00) begin
            n_err++;
            $display("FAIL reset_state: got st=%0d run=%b alm=%b want 0/0/0", state, running, alarm);
        end
        n_vec++;
        if (digits !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_digits: got %h want 0000", digits);
        end
        reset = 1'b0;
        step();
        n_vec++;
        if (digits !== 16'h0507) begin
            n_err++;
            $display("FAIL reset_release_load: got %h want 0507", digits);
        end
    endtask

    task automatic test_idle_load();
        preset_mins = 7'd127;
        preset_secs = 6'd63;
        step();
        n_vec++;
        if (digits !== 16'h9959) begin
            n_err++;
            $display("FAIL idle_clamp: got %h want 9959", digits);
        end
        preset_mins = 7'd42;
        preset_secs = 6'd17;
        step();
        n_vec++;
        if (digits !== 16'h4217) begin
            n_err++;
            $display("FAIL idle_convert: got %h want 4217", digits);
        end
        preset_mins = 7'd0;
        preset_secs = 6'd0;
        step();
        press();
        step();
        n_vec++;
        if (state !== 4'd0 || running !== 1'b0 || digits !== 16'h0000) begin
            n_err++;
            $display("FAIL zero_start: got st=%0d run=%b dig=%h want 0/0/0000", state, running, digits);
        end
    endtask

    task automatic test_countdown();
        logic [15:0] exp;
        preset_mins = 7'd0;
        preset_secs = 6'd3;
        press();
        n_vec++;
        if (state !== 4'd1 || running !== 1'b1 || digits !== 16'h0003) begin
            n_err++;
            $display("FAIL cd_start: got st=%0d run=%b dig=%h want 1/1/0003", state, running, digits);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            exp = 16'(3 - k / 4);
            n_vec++;
            if (digits !== exp) begin
                n_err++;
                $display("FAIL cd_digits cycle %0d: got %h want %h", k, digits, exp);
            end
            if (k == 11) begin
                n_vec++;
                if (state !== 4'd1 || alarm !== 1'b0) begin
                    n_err++;
                    $display("FAIL cd_pre_alarm: got st=%0d alm=%b want 1/0", state, alarm);
                end
            end
        end
        n_vec++;
        if (state !== 4'd3 || alarm !== 1'b1 || running !== 1'b0) begin
            n_err++;
            $display("FAIL cd_alarm: got st=%0d alm=%b run=%b want 3/1/0", state, alarm, running);
        end
    endtask

    task automatic test_alarm_exit();
`ifdef EGG_TIMER_AUTO_CLEAR_EN
        step(7);
        n_vec++;
        if (alarm !== 1'b1 || state !== 4'd3) begin
            n_err++;
            $display("FAIL autoclr_hold: got st=%0d alm=%b want 3/1", state, alarm);
        end
        step();
        n_vec++;
        if (alarm !== 1'b0 || state !== 4'd0 || digits !== 16'h0003) begin
            n_err++;
            $display("FAIL autoclr_idle: got st=%0d alm=%b dig=%h want 0/0/0003", state, alarm, digits);
        end
`else
        step(100);
        n_vec++;
        if (alarm !== 1'b1 || state !== 4'd3) begin
            n_err++;
            $display("FAIL alarm_persist: got st=%0d alm=%b want 3/1", state, alarm);
        end
        press();
        n_vec++;
        if (alarm !== 1'b0 || state !== 4'd0 || digits !== 16'h0003) begin
            n_err++;
            $display("FAIL alarm_ack: got st=%0d alm=%b dig=%h want 0/0/0003", state, alarm, digits);
        end
`endif
    endtask

    task automatic test_borrow();
        preset_mins = 7'd10;
        preset_secs = 6'd0;
        press();
        step(4);
        n_vec++;
        if (digits !== 16'h0959) begin
            n_err++;
            $display("FAIL borrow_10m: got %h want 0959", digits);
        end
        clear = 1'b1;
        preset_mins = 7'd1;
        step();
        clear = 1'b0;
        step();
        n_vec++;
        if (state !== 4'd0 || digits !== 16'h0100) begin
            n_err++;
            $display("FAIL borrow_clear: got st=%0d dig=%h want 0/0100", state, digits);
        end
        press();
        step(4);
        n_vec++;
        if (digits !== 16'h0059) begin
            n_err++;
            $display("FAIL borrow_1m: got %h want 0059", digits);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_pause();
        preset_mins = 7'd0;
        preset_secs = 6'd10;
        press();
        step();
        press();
        n_vec++;
        if (state !== 4'd2 || running !== 1'b0) begin
            n_err++;
            $display("FAIL pause_enter: got st=%0d run=%b want 2/0", state, running);
        end
        preset_mins = 7'd55;
        preset_secs = 6'd55;
        step(20);
        n_vec++;
        if (state !== 4'd2 || digits !== 16'h0010) begin
            n_err++;
            $display("FAIL pause_frozen: got st=%0d dig=%h want 2/0010", state, digits);
        end
        press();
        step();
        n_vec++;
        if (state !== 4'd1 || digits !== 16'h0010) begin
            n_err++;
            $display("FAIL resume_early: got st=%0d dig=%h want 1/0010", state, digits);
        end
        step();
        n_vec++;
        if (digits !== 16'h0009) begin
            n_err++;
            $display("FAIL resume_tick: got %h want 0009", digits);
        end
    endtask

    task automatic test_clear_wins();
        clear = 1'b1;
        start_stop = 1'b1;
        preset_mins = 7'd3;
        preset_secs = 6'd21;
        step();
        clear = 1'b0;
        start_stop = 1'b0;
        n_vec++;
        if (state !== 4'd0 || running !== 1'b0) begin
            n_err++;
            $display("FAIL clear_wins_state: got st=%0d run=%b want 0/0", state, running);
        end
        step();
        n_vec++;
        if (digits !== 16'h0321) begin
            n_err++;
            $display("FAIL clear_wins_digits: got %h want 0321", digits);
        end
    endtask

    task automatic test_tick_pause();
        preset_mins = 7'd0;
        preset_secs = 6'd5;
        press();
        step(3);
        press();
        n_vec++;
        if (state !== 4'd2 || digits !== 16'h0004) begin
            n_err++;
            $display("FAIL tick_pause: got st=%0d dig=%h want 2/0004", state, digits);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        preset_mins = 7'd0;
        preset_secs = 6'd9;
        press();
        step(5);
        reset = 1'b1;
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        n_vec++;
        if (state !== 4'd0 || running !== 1'b0 || digits !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_mid_run: got st=%0d run=%b dig=%h want 0/0/0000", state, running, digits);
        end
        reset = 1'b0;
        step();
        n_vec++;
        if (digits !== 16'h0009 || state !== 4'd0) begin
            n_err++;
            $display("FAIL reset_reload: got st=%0d dig=%h want 0/0009", state, digits);
        end
    endtask

    initial begin
        test_reset();
        test_idle_load();
        test_countdown();
        test_alarm_exit();
        test_borrow();
        test_pause();
        test_clear_wins();
        test_tick_pause();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
